// File: rtl/gemm_result_writer.sv
// -----------------------------------------------------------------------------
// gemm_result_writer
//
// Purpose:
//   Output stage behind the GeMM controller and MAC array. It accepts one
//   finished accumulator tile (TileRows x TileCols elements plus the tile's
//   M/N indices) and drains it row-by-row into the C SRAM through a req/gnt
//   write port. One SRAM word holds one tile row. Rows and columns that fall
//   outside the true matrix sizes are masked: out-of-range rows are never
//   written, and out-of-range columns get a cleared byte-lane strobe.
//
// Ports:
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   tile_valid_i    producer offers a tile
//   tile_ready_o    writer can take a tile (high only when idle)
//   tile_data_i     element (r,c) at [(r*TileCols+c)*DataWidth +: DataWidth]
//   tile_m_i        tile row index, in units of TileRows
//   tile_n_i        tile column index, in units of TileCols
//   tile_last_i     final tile of the GeMM
//   M_size_i        true M (held stable while busy_o)
//   N_size_i        true N (held stable while busy_o)
//   base_addr_i     C base word address (held stable while busy_o)
//   sram_req_o      write request
//   sram_gnt_i      write accepted this cycle
//   sram_addr_o     word address, zero when not requesting
//   sram_wdata_o    one tile row, zero when not requesting
//   sram_strb_o     per-element write enable, zero when not requesting
//   busy_o          a tile is held, being written, or done is pulsing
//   done_o          one-cycle pulse after the last row of the last tile
// -----------------------------------------------------------------------------
module gemm_result_writer #(
  parameter int DataWidth = 32,
  parameter int TileRows  = 4,
  parameter int TileCols  = 16,
  parameter int AddrWidth = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 tile_valid_i,
  output logic                                 tile_ready_o,
  input  logic [TileRows*TileCols*DataWidth-1:0] tile_data_i,
  input  logic [AddrWidth-1:0]                 tile_m_i,
  input  logic [AddrWidth-1:0]                 tile_n_i,
  input  logic                                 tile_last_i,
  input  logic [AddrWidth-1:0]                 M_size_i,
  input  logic [AddrWidth-1:0]                 N_size_i,
  input  logic [AddrWidth-1:0]                 base_addr_i,
  output logic                                 sram_req_o,
  input  logic                                 sram_gnt_i,
  output logic [AddrWidth-1:0]                 sram_addr_o,
  output logic [TileCols*DataWidth-1:0]        sram_wdata_o,
  output logic [TileCols-1:0]                  sram_strb_o,
  output logic                                 busy_o,
  output logic                                 done_o
);

  localparam int RowBits  = TileCols * DataWidth;
  localparam int TileBits = TileRows * RowBits;
  // Extra headroom so tile_index * tile_dim never wraps before the clamp.
  localparam int ExtW     = AddrWidth + 4;
  localparam int RowIdxW  = (TileRows > 1) ? $clog2(TileRows) : 1;
  localparam int RowCntW  = $clog2(TileRows + 1);
  localparam int ColCntW  = $clog2(TileCols + 1);

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [TileBits-1:0]  tile_data_q;
  logic [AddrWidth-1:0] tile_m_q;
  logic [AddrWidth-1:0] tile_n_q;
  logic                 tile_last_q;
  logic [RowCntW-1:0]   rows_v_q;
  logic [ColCntW-1:0]   cols_v_q;
  logic [RowIdxW-1:0]   row_q, row_d;
  logic                 capture;

  // ---------------------------------------------------------------------------
  // Valid extent of the offered tile, evaluated while idle and stored on
  // capture. Both extents clamp to 0 when the tile starts past the matrix edge.
  // ---------------------------------------------------------------------------
  logic [ExtW-1:0]    m_start, n_start;
  logic [ExtW-1:0]    m_left, n_left;
  logic [RowCntW-1:0] rows_v_new;
  logic [ColCntW-1:0] cols_v_new;

  assign m_start = ExtW'(tile_m_i) * ExtW'(TileRows);
  assign n_start = ExtW'(tile_n_i) * ExtW'(TileCols);
  assign m_left  = (ExtW'(M_size_i) > m_start) ? (ExtW'(M_size_i) - m_start) : '0;
  assign n_left  = (ExtW'(N_size_i) > n_start) ? (ExtW'(N_size_i) - n_start) : '0;

  assign rows_v_new = (m_left > ExtW'(TileRows)) ? RowCntW'(TileRows) : RowCntW'(m_left);
  assign cols_v_new = (n_left > ExtW'(TileCols)) ? ColCntW'(TileCols) : ColCntW'(n_left);

  // ---------------------------------------------------------------------------
  // Address generation. The row stride of C is the number of SRAM words per
  // matrix row, i.e. ceil(N / TileCols). The final sum deliberately wraps
  // modulo 2^AddrWidth.
  // ---------------------------------------------------------------------------
  logic [ExtW-1:0]      stride_ext;
  logic [AddrWidth-1:0] stride;
  logic [AddrWidth-1:0] line_idx;
  logic [AddrWidth-1:0] addr_calc;

  assign stride_ext = (ExtW'(N_size_i) + ExtW'(TileCols - 1)) / ExtW'(TileCols);
  assign stride     = stride_ext[AddrWidth-1:0];
  assign line_idx   = (tile_m_q * AddrWidth'(TileRows)) + AddrWidth'(row_q);
  assign addr_calc  = base_addr_i + (line_idx * stride) + tile_n_q;

  // ---------------------------------------------------------------------------
  // Row selection and column masking
  // ---------------------------------------------------------------------------
  logic [RowBits-1:0]  row_words [TileRows];
  logic [TileCols-1:0] strb_mask;

  for (genvar gi = 0; gi < TileRows; gi++) begin : g_rows
    assign row_words[gi] = tile_data_q[gi*RowBits +: RowBits];
  end

  for (genvar gi = 0; gi < TileCols; gi++) begin : g_strb
    assign strb_mask[gi] = (ColCntW'(gi) < cols_v_q);
  end

  logic last_row;
  assign last_row = ((RowCntW'(row_q) + RowCntW'(1)) == rows_v_q);

  // ---------------------------------------------------------------------------
  // State register and captured tile
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      row_q       <= '0;
      tile_data_q <= '0;
      tile_m_q    <= '0;
      tile_n_q    <= '0;
      tile_last_q <= 1'b0;
      rows_v_q    <= '0;
      cols_v_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      if (capture) begin
        tile_data_q <= tile_data_i;
        tile_m_q    <= tile_m_i;
        tile_n_q    <= tile_n_i;
        tile_last_q <= tile_last_i;
        rows_v_q    <= rows_v_new;
        cols_v_q    <= cols_v_new;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic. Outputs are decoded from the state so that
  // an asynchronous reset clears them immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    capture      = 1'b0;
    tile_ready_o = 1'b0;
    sram_req_o   = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_strb_o  = '0;
    busy_o       = 1'b1;
    done_o       = 1'b0;

    unique case (state_q)
      StIdle: begin
        tile_ready_o = 1'b1;
        busy_o       = 1'b0;
        if (tile_valid_i) begin
          capture = 1'b1;
          row_d   = '0;
          if ((rows_v_new != '0) && (cols_v_new != '0)) begin
            state_d = StWrite;
          end else if (tile_last_i) begin
            // Fully masked final tile: nothing to write, still signal done.
            state_d = StDone;
          end
        end
      end

      StWrite: begin
        sram_req_o   = 1'b1;
        sram_addr_o  = addr_calc;
        sram_wdata_o = row_words[row_q];
        sram_strb_o  = strb_mask;
        if (sram_gnt_i) begin
          if (last_row) begin
            row_d   = '0;
            state_d = tile_last_q ? StDone : StIdle;
          end else begin
            // Next row is presented in the very next cycle.
            row_d = row_q + RowIdxW'(1);
          end
        end
      end

      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: doc/gemm_result_writer.md
Name: gemm_result_writer

Overview:
- Output stage directly downstream of the GeMM controller and 4x16 MAC array.
- Accepts one completed accumulator tile per handshake: TileRows x TileCols elements plus the tile's M/N indices.
- Drains the tile row-by-row into the output (C) SRAM through a req/gnt write port.
- Generates C addresses and masks out rows and columns that fall outside the true M/N sizes.

Parameters:
- DataWidth, 32, width of one result element.
- TileRows, 4, rows per tile (M parallelism).
- TileCols, 16, columns per tile (N parallelism); one SRAM word = one tile row.
- AddrWidth, 16, width of sizes, tile indices and SRAM address.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- tile_valid_i  in  1  tile available.
- tile_ready_o  out  1  writer can accept a tile.
- tile_data_i  in  TileRows*TileCols*DataWidth  element (r,c) at [(r*TileCols+c)*DataWidth +: DataWidth].
- tile_m_i  in  AddrWidth  tile row index (units of TileRows).
- tile_n_i  in  AddrWidth  tile column index (units of TileCols).
- tile_last_i  in  1  this tile is the final tile of the GeMM.
- M_size_i  in  AddrWidth  true M; stable while busy_o.
- N_size_i  in  AddrWidth  true N; stable while busy_o.
- base_addr_i  in  AddrWidth  C matrix base word address; stable while busy_o.
- sram_req_o  out  1  write request.
- sram_gnt_i  in  1  write accepted this cycle.
- sram_addr_o  out  AddrWidth  word address.
- sram_wdata_o  out  TileCols*DataWidth  one tile row, column c at [c*DataWidth +: DataWidth].
- sram_strb_o  out  TileCols  per-element write enable.
- busy_o  out  1  tile held or being written.
- done_o  out  1  one-cycle pulse after the last row of the last tile is granted.

Behaviour:
- Reset values: state Idle, tile_ready_o=1, sram_req_o=0, sram_addr_o=0, sram_wdata_o=0, sram_strb_o=0, busy_o=0, done_o=0. Captured tile is discarded.
- States:
  - Idle:
    - tile_ready_o=1.
    - On tile_valid_i, capture tile_data_i, tile_m_i, tile_n_i and tile_last_i into registers.
    - Compute rows_v = min(TileRows, M_size_i - tile_m_i*TileRows) and cols_v = min(TileCols, N_size_i - tile_n_i*TileCols), each clamped to 0 if the subtraction is non-positive. Arithmetic is on AddrWidth+4 bits to avoid wrap.
    - If rows_v>0 and cols_v>0, go to Write with row=0.
    - Otherwise drop the tile with no SRAM access: go to Done if last, else stay Idle.
  - Write:
    - tile_ready_o=0, sram_req_o=1.
    - sram_addr_o = base_addr_i + (tile_m*TileRows + row)*stride + tile_n, where stride = ceil(N_size_i/TileCols). Result is truncated to AddrWidth (wraps modulo 2^AddrWidth).
    - sram_wdata_o = captured row `row`.
    - sram_strb_o bit c = (c < cols_v).
    - addr, wdata and strb hold stable until sram_gnt_i.
    - On grant: if row == rows_v-1, go to Done if last, else Idle. Otherwise row++ and the next request is issued in the following cycle (back-to-back, no bubble).
  - Done: done_o=1 for exactly one cycle, sram_req_o=0, then go to Idle.
- When sram_req_o=0, sram_addr_o, sram_wdata_o and sram_strb_o are driven 0.
- busy_o = (state != Idle).
- tile_ready_o is high only in Idle, so there is no capture overlap with draining.
- Latency: first request is issued the cycle after acceptance. A full tile with gnt tied high finishes in 1 + TileRows cycles, plus one Done cycle if last.
- sram_gnt_i while sram_req_o=0 is ignored.
- tile_valid_i held high outside Idle is not consumed and must be held by the producer.
- Asynchronous reset mid-Write: sram_req_o drops immediately; no further writes from the aborted tile after reset release.

Test Plan:
- M=4, N=16, base=0x100, tile (0,0) last, gnt=1: writes addr 0x100 with row 0 data, strb 0xFFFF. No wait: stride=1, so writes go to 0x100, 0x101, 0x102, 0x103 in 4 consecutive cycles, each strb 0xFFFF. Then done_o pulses once and tile_ready_o returns to 1.
- M=6, N=20, base=0, tile (1,1) last: stride=2, rows_v=2, cols_v=4. Exactly 2 writes, addr 9 then 11, strb 0x000F, data = rows 0 and 1. Then done_o.
- Back-pressure: M=4, N=16, gnt low 3 cycles on each row. sram_addr_o, sram_wdata_o and sram_strb_o stay constant while waiting. Exactly 4 grants. tile_ready_o stays 0 throughout.
- Out-of-range tile: M=4, N=16, tile (1,0) not last. Accepted with no sram_req_o and no done_o; busy_o never rises. The same tile with last=1 produces a done_o pulse only.
- Reset mid-operation: assert rst_ni=0 after the 2nd grant of a 4-row tile. All outputs drop to reset values asynchronously, and after release no further requests occur.
- Back-to-back tiles: M=8, N=32, four tiles (0,0), (0,1), (1,0), (1,1), last on the final tile, gnt=1. 16 writes to addresses {0,2,4,6}, {1,3,5,7}, {8,10,12,14}, {9,11,13,15}. Exactly one done_o pulse.
